// File: rtl/buffer_1.sv
// buffer_1: fetches a 3x3 window of pixels one word at a time, reduces each to 8 bits, presents all nine in parallel.
// Latency: read request one edge after i_load; each captured pixel visible one edge after its i_read_complete.
// Backpressure: no new fetch until the datapath consumes the full window; the reader is paced by read_enable/read_complete.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   i_load              level request to start fetching a window (only honoured when empty)
//   i_consume           one-cycle pulse: datapath has taken the full window
//   i_read_data         {R,G,B,pad} pixel word from the memory reader
//   i_read_complete     one-cycle pulse: i_read_data valid
//   o_read_enable       read request to the memory reader
//   o_empty, o_full     registered window occupancy flags (count==0 / count==9)
//   o_pixel_1..9        window pixels in raster order, 1 = top-left
//
// Optional feature macro BUFFER_1_GRAY_EN: when defined each pixel is the
// luminance (R + 2G + B) >> 2; otherwise the R channel is taken as-is.

module buffer_1 #(
   parameter int GAP_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_consume,
   input  logic [31:0] i_read_data,
   input  logic        i_read_complete,
   output logic        o_read_enable,
   output logic        o_empty,
   output logic        o_full,
   output logic [7:0]  o_pixel_1,
   output logic [7:0]  o_pixel_2,
   output logic [7:0]  o_pixel_3,
   output logic [7:0]  o_pixel_4,
   output logic [7:0]  o_pixel_5,
   output logic [7:0]  o_pixel_6,
   output logic [7:0]  o_pixel_7,
   output logic [7:0]  o_pixel_8,
   output logic [7:0]  o_pixel_9
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2,
      FULL = 2'd3
   } state_t;

   // Last value of the gap counter before returning to REQ.
   localparam logic [1:0] GAP_LAST = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  count;
   logic [3:0]  count_nxt;
   logic [1:0]  gap_cnt;
   logic [7:0]  slot [0:8];
   logic [7:0]  luma;
   logic        capture;
   logic        unused_bits;

`ifdef BUFFER_1_GRAY_EN
   logic [9:0]  luma_sum;

   // Worst case 255 + 510 + 255 = 1020 fits in 10 bits; >>2 always fits in 8.
   assign luma_sum    = {2'b00, i_read_data[31:24]}
                      + {1'b0, i_read_data[23:16], 1'b0}
                      + {2'b00, i_read_data[15:8]};
   assign luma        = luma_sum[9:2];
   assign unused_bits = ^{luma_sum[1:0], i_read_data[7:0]};
`else
   // Source assumed grayscale: R already equals the luminance.
   assign luma        = i_read_data[31:24];
   assign unused_bits = ^i_read_data[23:0];
`endif

   // A word is only taken while a request is outstanding.
   assign capture = (state == REQ) && i_read_complete;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      count_nxt     = count;
      o_read_enable = 1'b0;
      case (state)
         IDLE: begin
            if (i_load && (count == 4'd0)) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            o_read_enable = 1'b1;
            if (capture) begin
               count_nxt = count + 4'd1;
               if (count == 4'd8) begin
                  state_nxt = FULL;
               end else if (GAP_CYCLES > 0) begin
                  state_nxt = GAP;
               end else begin
                  state_nxt = REQ;
               end
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt = REQ;
            end
         end
         FULL: begin
            // Consume has priority over a simultaneous load; load is seen again in IDLE.
            if (i_consume) begin
               count_nxt = 4'd0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= 4'd0;
         gap_cnt <= 2'd0;
         o_empty <= 1'b1;
         o_full  <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            slot[i] <= 8'd0;
         end
      end else begin
         count   <= count_nxt;
         o_empty <= (count_nxt == 4'd0);
         o_full  <= (count_nxt == 4'd9);
         // Counter runs only while idling between requests, restarts each gap.
         if (state == GAP) begin
            gap_cnt <= gap_cnt + 2'd1;
         end else begin
            gap_cnt <= 2'd0;
         end
         // Slots persist after consume until the next fetch overwrites them.
         if (capture) begin
            for (int i = 0; i < 9; i++) begin
               if (count == 4'(i)) begin
                  slot[i] <= luma;
               end
            end
         end
      end
   end

   assign o_pixel_1 = slot[0];
   assign o_pixel_2 = slot[1];
   assign o_pixel_3 = slot[2];
   assign o_pixel_4 = slot[3];
   assign o_pixel_5 = slot[4];
   assign o_pixel_6 = slot[5];
   assign o_pixel_7 = slot[6];
   assign o_pixel_8 = slot[7];
   assign o_pixel_9 = slot[8];

endmodule

// File: tb/tb_buffer_1.sv
// tb_buffer_1: self-checking bench for buffer_1 with a gap-of-one instance and a back-to-back instance.
// Latency: stimulus driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: the bench plays the memory reader, answering each read request with a delayed complete pulse.

module tb_buffer_1;

   logic tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   logic        rst;

   // Instance with GAP_CYCLES = 1
   logic        load, consume, rcmp;
   logic [31:0] rdata;
   logic        en, empty, full;
   logic [7:0]  pix [9];

   // Instance with GAP_CYCLES = 0
   logic        load0, consume0, rcmp0;
   logic [31:0] rdata0;
   logic        en0, empty0, full0;
   logic [7:0]  pix0 [9];

   int n_pass  = 0;
   int n_total = 0;
   logic [7:0] exp_q [$];

   buffer_1 #(.GAP_CYCLES(1)) dut (
      .clk(tb_clk), .rst(rst), .i_load(load), .i_consume(consume),
      .i_read_data(rdata), .i_read_complete(rcmp),
      .o_read_enable(en), .o_empty(empty), .o_full(full),
      .o_pixel_1(pix[0]), .o_pixel_2(pix[1]), .o_pixel_3(pix[2]),
      .o_pixel_4(pix[3]), .o_pixel_5(pix[4]), .o_pixel_6(pix[5]),
      .o_pixel_7(pix[6]), .o_pixel_8(pix[7]), .o_pixel_9(pix[8])
   );

   buffer_1 #(.GAP_CYCLES(0)) dut0 (
      .clk(tb_clk), .rst(rst), .i_load(load0), .i_consume(consume0),
      .i_read_data(rdata0), .i_read_complete(rcmp0),
      .o_read_enable(en0), .o_empty(empty0), .o_full(full0),
      .o_pixel_1(pix0[0]), .o_pixel_2(pix0[1]), .o_pixel_3(pix0[2]),
      .o_pixel_4(pix0[3]), .o_pixel_5(pix0[4]), .o_pixel_6(pix0[5]),
      .o_pixel_7(pix0[6]), .o_pixel_8(pix0[7]), .o_pixel_9(pix0[8])
   );

   // Reference pixel reduction.
   function automatic logic [7:0] luma_of(input logic [31:0] w);
`ifdef BUFFER_1_GRAY_EN
      int s;
      s = int'(w[31:24]) + 2 * int'(w[23:16]) + int'(w[15:8]);
      return 8'(s / 4);
`else
      return w[31:24];
`endif
   endfunction

   task automatic wait_en(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (en === 1'b1) begin
            ok = 1'b1;
            return;
         end
         @(negedge tb_clk);
      end
   endtask

   // Memory reader model: answers a pending request two cycles later.
   task automatic answer(input logic [31:0] w);
      bit ok;
      wait_en(ok);
      n_total++;
      if (!ok) $display("FAIL req_timeout got read_enable=%b want 1", en);
      else n_pass++;
      @(posedge tb_clk);
      @(posedge tb_clk);
      #1;
      rdata = w;
      rcmp  = 1'b1;
      exp_q.push_back(luma_of(w));
      @(posedge tb_clk);
      #1;
      rcmp  = 1'b0;
   endtask

   task automatic test_reset;
      @(posedge tb_clk);
      @(negedge tb_clk);
      n_total++; if (empty !== 1'b1) $display("FAIL rst_empty got %b want 1", empty); else n_pass++;
      n_total++; if (full !== 1'b0) $display("FAIL rst_full got %b want 0", full); else n_pass++;
      n_total++; if (en !== 1'b0) $display("FAIL rst_en got %b want 0", en); else n_pass++;
      for (int i = 0; i < 9; i++) begin
         n_total++;
         if (pix[i] !== 8'd0) $display("FAIL rst_pix%0d got %0d want 0", i + 1, pix[i]);
         else n_pass++;
      end
      @(posedge tb_clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_full_fetch;
      logic [7:0] vals [9];
      int gap;
      vals = '{8'd12, 8'd21, 8'd252, 8'd40, 8'd67, 8'd255, 8'd117, 8'd134, 8'd239};
      exp_q.delete();
      load = 1'b1;
      @(posedge tb_clk);
      #1;
      load = 1'b0;
      for (int i = 0; i < 9; i++) begin
         answer({vals[i], vals[i], vals[i], 8'h00});
         if (i < 8) begin
            gap = 0;
            @(negedge tb_clk);
            while (en !== 1'b1 && gap < 10) begin
               gap++;
               @(negedge tb_clk);
            end
            n_total++;
            if (gap != 1) $display("FAIL gap_len word%0d got %0d want 1", i, gap);
            else n_pass++;
         end
      end
      @(negedge tb_clk);
      n_total++; if (full !== 1'b1) $display("FAIL fetch_full got %b want 1", full); else n_pass++;
      n_total++; if (empty !== 1'b0) $display("FAIL fetch_empty got %b want 0", empty); else n_pass++;
      n_total++; if (en !== 1'b0) $display("FAIL fetch_en got %b want 0", en); else n_pass++;
      for (int i = 0; i < 9; i++) begin
         n_total++;
         if (exp_q.size() == 0) $display("FAIL fetch_pix%0d got %0d want scoreboard entry", i + 1, pix[i]);
         else if (pix[i] !== exp_q[0]) $display("FAIL fetch_pix%0d got %0d want %0d", i + 1, pix[i], exp_q.pop_front());
         else begin n_pass++; void'(exp_q.pop_front()); end
      end
   endtask

   task automatic test_consume_reload;
      logic [7:0]  saved [9];
      logic [31:0] words [9];
      logic [7:0]  want_mix;
`ifdef BUFFER_1_GRAY_EN
      want_mix = 8'd80;
`else
      want_mix = 8'd40;
`endif
      words = '{32'h2850_7800, 32'hFFFF_FF00, 32'h0A14_1E00, 32'h3C3C_3C00, 32'h8040_2000,
                32'h0000_00FF, 32'h64C8_3200, 32'h1111_11AB, 32'hF0E0_D000};
      for (int i = 0; i < 9; i++) saved[i] = pix[i];
      @(posedge tb_clk);
      #1;
      load    = 1'b1;
      consume = 1'b1;
      @(posedge tb_clk);
      #1;
      consume = 1'b0;
      @(negedge tb_clk);
      n_total++; if (empty !== 1'b1) $display("FAIL consume_empty got %b want 1", empty); else n_pass++;
      n_total++; if (full !== 1'b0) $display("FAIL consume_full got %b want 0", full); else n_pass++;
      n_total++; if (en !== 1'b0) $display("FAIL consume_idle_en got %b want 0", en); else n_pass++;
      for (int i = 0; i < 9; i++) begin
         n_total++;
         if (pix[i] !== saved[i]) $display("FAIL consume_keep_pix%0d got %0d want %0d", i + 1, pix[i], saved[i]);
         else n_pass++;
      end
      @(negedge tb_clk);
      n_total++; if (en !== 1'b1) $display("FAIL reload_en got %b want 1", en); else n_pass++;
      load = 1'b0;
      exp_q.delete();
      answer(words[0]);
      @(negedge tb_clk);
      n_total++; if (pix[0] !== want_mix) $display("FAIL luma_mix got %0d want %0d", pix[0], want_mix); else n_pass++;
      n_total++; if (pix[1] !== saved[1]) $display("FAIL reload_pix2_kept got %0d want %0d", pix[1], saved[1]); else n_pass++;
      answer(words[1]);
      @(negedge tb_clk);
      n_total++; if (pix[1] !== 8'd255) $display("FAIL luma_white got %0d want 255", pix[1]); else n_pass++;
      for (int i = 2; i < 9; i++) answer(words[i]);
      @(negedge tb_clk);
      n_total++; if (full !== 1'b1) $display("FAIL reload_full got %b want 1", full); else n_pass++;
      for (int i = 0; i < 9; i++) begin
         n_total++;
         if (exp_q.size() == 0) $display("FAIL reload_pix%0d got %0d want scoreboard entry", i + 1, pix[i]);
         else if (pix[i] !== exp_q[0]) $display("FAIL reload_pix%0d got %0d want %0d", i + 1, pix[i], exp_q.pop_front());
         else begin n_pass++; void'(exp_q.pop_front()); end
      end
   endtask

   task automatic test_spurious;
      logic [7:0] keep1;
      @(posedge tb_clk);
      #1;
      consume = 1'b1;
      @(posedge tb_clk);
      #1;
      consume = 1'b0;
      keep1 = pix[0];
      // Complete pulse while idle
      rdata = 32'h7777_7700;
      rcmp  = 1'b1;
      @(posedge tb_clk);
      #1;
      rcmp  = 1'b0;
      @(negedge tb_clk);
      n_total++; if (empty !== 1'b1) $display("FAIL idle_cmp_empty got %b want 1", empty); else n_pass++;
      n_total++; if (pix[0] !== keep1) $display("FAIL idle_cmp_pix1 got %0d want %0d", pix[0], keep1); else n_pass++;
      exp_q.delete();
      load = 1'b1;  // held for the whole fetch
      for (int i = 0; i < 9; i++) begin
         answer({8'(i * 23 + 5), 8'(i * 7 + 100), 8'(250 - i * 9), 8'h33});
         if (i == 1) begin
            // In GAP: this pulse must not be captured
            rdata = 32'h5555_5500;
            rcmp  = 1'b1;
            @(posedge tb_clk);
            #1;
            rcmp  = 1'b0;
         end
         if (i == 3) begin
            consume = 1'b1;
            @(posedge tb_clk);
            #1;
            consume = 1'b0;
            @(negedge tb_clk);
            n_total++; if (empty !== 1'b0) $display("FAIL early_consume_empty got %b want 0", empty); else n_pass++;
            n_total++; if (full !== 1'b0) $display("FAIL early_consume_full got %b want 0", full); else n_pass++;
         end
      end
      load = 1'b0;
      @(negedge tb_clk);
      n_total++; if (full !== 1'b1) $display("FAIL spur_full got %b want 1", full); else n_pass++;
      for (int i = 0; i < 9; i++) begin
         n_total++;
         if (exp_q.size() == 0) $display("FAIL spur_pix%0d got %0d want scoreboard entry", i + 1, pix[i]);
         else if (pix[i] !== exp_q[0]) $display("FAIL spur_pix%0d got %0d want %0d", i + 1, pix[i], exp_q.pop_front());
         else begin n_pass++; void'(exp_q.pop_front()); end
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      @(posedge tb_clk);
      #1;
      consume = 1'b1;
      load    = 1'b1;
      @(posedge tb_clk);
      #1;
      consume = 1'b0;
      @(posedge tb_clk);
      #1;
      load    = 1'b0;
      for (int i = 0; i < 3; i++) answer(32'h9090_9000 + (i << 24));
      wait_en(ok);
      n_total++; if (!ok) $display("FAIL mid_req_timeout got read_enable=%b want 1", en); else n_pass++;
      rst   = 1'b1;
      rdata = 32'hABCD_EF00;
      rcmp  = 1'b1;
      @(posedge tb_clk);
      #1;
      rcmp  = 1'b0;
      @(negedge tb_clk);
      n_total++; if (empty !== 1'b1) $display("FAIL mid_rst_empty got %b want 1", empty); else n_pass++;
      n_total++; if (full !== 1'b0) $display("FAIL mid_rst_full got %b want 0", full); else n_pass++;
      n_total++; if (en !== 1'b0) $display("FAIL mid_rst_en got %b want 0", en); else n_pass++;
      for (int i = 0; i < 9; i++) begin
         n_total++;
         if (pix[i] !== 8'd0) $display("FAIL mid_rst_pix%0d got %0d want 0", i + 1, pix[i]);
         else n_pass++;
      end
      @(posedge tb_clk);
      #1;
      rst = 1'b0;
      @(negedge tb_clk);
      n_total++; if (empty !== 1'b1) $display("FAIL post_rst_empty got %b want 1", empty); else n_pass++;
      n_total++; if (en !== 1'b0) $display("FAIL post_rst_en got %b want 0", en); else n_pass++;
   endtask

   task automatic test_back_to_back;
      exp_q.delete();
      @(posedge tb_clk);
      #1;
      load0 = 1'b1;
      @(posedge tb_clk);
      #1;
      load0 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         rdata0 = {8'(i * 29 + 3), 8'(i * 17), 8'(200 - i * 11), 8'h5A};
         rcmp0  = 1'b1;
         exp_q.push_back(luma_of(rdata0));
         @(negedge tb_clk);
         n_total++; if (en0 !== 1'b1) $display("FAIL b2b_en word%0d got %b want 1", i, en0); else n_pass++;
         @(posedge tb_clk);
         #1;
         if (i < 8) begin
            n_total++; if (full0 !== 1'b0) $display("FAIL b2b_early_full word%0d got %b want 0", i, full0); else n_pass++;
         end
      end
      rcmp0 = 1'b0;
      @(negedge tb_clk);
      n_total++; if (full0 !== 1'b1) $display("FAIL b2b_full got %b want 1", full0); else n_pass++;
      n_total++; if (empty0 !== 1'b0) $display("FAIL b2b_empty got %b want 0", empty0); else n_pass++;
      n_total++; if (en0 !== 1'b0) $display("FAIL b2b_en_done got %b want 0", en0); else n_pass++;
      for (int i = 0; i < 9; i++) begin
         n_total++;
         if (exp_q.size() == 0) $display("FAIL b2b_pix%0d got %0d want scoreboard entry", i + 1, pix0[i]);
         else if (pix0[i] !== exp_q[0]) $display("FAIL b2b_pix%0d got %0d want %0d", i + 1, pix0[i], exp_q.pop_front());
         else begin n_pass++; void'(exp_q.pop_front()); end
      end
   endtask

   initial begin
      rst      = 1'b1;
      load     = 1'b0; consume  = 1'b0; rcmp  = 1'b0; rdata  = 32'h0;
      load0    = 1'b0; consume0 = 1'b0; rcmp0 = 1'b0; rdata0 = 32'h0;
      test_reset;
      test_full_fetch;
      test_consume_reload;
      test_spurious;
      test_reset_mid;
      test_back_to_back;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion (%0d/%0d done)", n_pass, n_total);
      $fatal(1);
   end

endmodule
